// File: rtl/axi_pkg.sv
// Shared AXI read-responder constants, FSM state type and request-entry width helper.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rsp_state_e;

  // Queue entry layout, MSB first: {id, addr, len, size[2:0], burst[1:0], t_acc[15:0]}
  function automatic int req_width(input int id_len, input int addr_len, input int len_size);
    return id_len + addr_len + len_size + 3 + 2 + 16;
  endfunction

endpackage

// File: rtl/axi_resp_fifo.sv
// Synchronous first-word-fall-through FIFO holding accepted AR requests.
module axi_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // The extra pointer MSB separates a full queue from an empty one.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/axi_read_responder.sv
// Read-only AXI slave model: queues AR requests and, after a programmable
// latency, returns address-pattern R bursts in acceptance order.
module axi_read_responder
  import axi_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 64,
  parameter int ID_LEN   = 6,
  parameter int LEN_SIZE = 4,
  parameter int DEPTH    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ID_LEN-1:0]   axi_arid,
  input  logic [ADDR_LEN-1:0] axi_araddr,
  input  logic [LEN_SIZE-1:0] axi_arlen,
  input  logic [2:0]          axi_arsize,
  input  logic [1:0]          axi_arburst,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  output logic [ID_LEN-1:0]   axi_rid,
  output logic [DATA_LEN-1:0] axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic                axi_rlast,
  output logic                axi_rvalid,
  input  logic                axi_rready,
  input  logic [15:0]         cfg_latency,
  output logic [31:0]         served_count,
  output rsp_state_e          dbg_state_o
);

  localparam int         REQ_W    = req_width(ID_LEN, ADDR_LEN, LEN_SIZE);
  localparam int         LANES    = DATA_LEN / ADDR_LEN;
  localparam int         CW       = $clog2(DEPTH) + 1;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_LEN / 8));

  // Handshakes: a transfer happens on a rising edge where valid && ready; a
  // raised valid and its payload stay stable until that transfer completes.

  logic [15:0]         now_q, now_d;
  logic [31:0]         served_q, served_d;
  logic                arready_q, arready_d;

  logic [REQ_W-1:0]    fifo_din, fifo_dout;
  logic                fifo_full, fifo_empty;
  logic [CW-1:0]       fifo_count, count_d;
  logic                push, pop;

  logic [ID_LEN-1:0]   h_id;
  logic [ADDR_LEN-1:0] h_addr;
  logic [LEN_SIZE-1:0] h_len;
  logic [2:0]          h_size;
  logic [1:0]          h_burst;
  logic [15:0]         h_tacc;
  logic [15:0]         h_age;
  logic                h_err;
  logic                head_elig;

  rsp_state_e          state_q;
  logic                rvalid_q, rlast_q;
  logic [ID_LEN-1:0]   rid_q;
  logic [DATA_LEN-1:0] rdata_q;
  logic [1:0]          rresp_q;
  logic [ADDR_LEN-1:0] beat_addr_q, next_addr;
  logic [LEN_SIZE-1:0] beat_cnt_q, len_q;
  logic [2:0]          size_q;
  logic                fixed_q;
  logic                beat_hs, last_hs;

  assign fifo_din = {axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, now_q};
  assign {h_id, h_addr, h_len, h_size, h_burst, h_tacc} = fifo_dout;

  axi_resp_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Modular age keeps eligibility correct across cycle-counter wrap.
  assign h_age     = now_q - h_tacc;
  assign head_elig = !fifo_empty && (h_age >= cfg_latency);
  assign h_err     = h_burst[1] || (h_size > MAX_SIZE);

  assign beat_hs = rvalid_q && axi_rready;
  assign last_hs = beat_hs && rlast_q;
  assign push    = axi_arvalid && arready_q && !fifo_full;
  assign pop     = head_elig && ((state_q == ST_IDLE) || last_hs);

  // arready reflects the occupancy after this cycle's push/pop, so a pop from
  // a full queue only reopens AR one cycle later.
  assign count_d   = fifo_count + CW'(push) - CW'(pop);
  assign arready_d = (count_d < CW'(DEPTH));
  assign now_d     = now_q + 16'd1;
  assign served_d  = served_q + 32'(last_hs);

  always_ff @(posedge clock) begin
    if (reset) begin
      now_q     <= '0;
      served_q  <= '0;
      arready_q <= 1'b0;
    end else begin
      now_q     <= now_d;
      served_q  <= served_d;
      arready_q <= arready_d;
    end
  end

  assign next_addr = fixed_q ? beat_addr_q : beat_addr_q + (ADDR_LEN'(1) << size_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rid_q       <= '0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      beat_addr_q <= '0;
      beat_cnt_q  <= '0;
      len_q       <= '0;
      size_q      <= '0;
      fixed_q     <= 1'b0;
    end else if (pop) begin
      // Entered from IDLE or straight from a finishing burst (no bubble).
      state_q     <= ST_BURST;
      rvalid_q    <= 1'b1;
      rlast_q     <= (h_len == '0);
      rid_q       <= h_id;
      rdata_q     <= {LANES{h_addr}};
      rresp_q     <= h_err ? RESP_SLVERR : RESP_OKAY;
      beat_addr_q <= h_addr;
      beat_cnt_q  <= '0;
      len_q       <= h_len;
      size_q      <= h_size;
      fixed_q     <= (h_burst == BURST_FIXED);
    end else if ((state_q == ST_BURST) && beat_hs) begin
      if (rlast_q) begin
        state_q  <= ST_IDLE;
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end else begin
        beat_addr_q <= next_addr;
        rdata_q     <= {LANES{next_addr}};
        beat_cnt_q  <= beat_cnt_q + LEN_SIZE'(1);
        rlast_q     <= ((beat_cnt_q + LEN_SIZE'(1)) == len_q);
      end
    end
  end

  assign axi_arready  = arready_q;
  assign axi_rvalid   = rvalid_q;
  assign axi_rlast    = rlast_q;
  assign axi_rid      = rid_q;
  assign axi_rdata    = rdata_q;
  assign axi_rresp    = rresp_q;
  assign served_count = served_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_axi_read_responder.sv
// Self-checking bench for axi_read_responder: directed scenarios plus random traffic
// checked against a burst-level reference model.
module tb_axi_read_responder;
  import axi_pkg::*;

  localparam int BW = 6 + 64 + 2 + 1;

  logic        clock;
  logic        reset;
  logic [5:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [5:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [15:0] cfg_latency;
  logic [31:0] served_count;
  rsp_state_e  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_served = 0;
  bit rr_mode = 0;

  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] rx_q[$];
  int            rx_cyc[$];

  axi_read_responder #(
    .ADDR_LEN(32), .DATA_LEN(64), .ID_LEN(6), .LEN_SIZE(4), .DEPTH(8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .axi_arid     (arid),
    .axi_araddr   (araddr),
    .axi_arlen    (arlen),
    .axi_arsize   (arsize),
    .axi_arburst  (arburst),
    .axi_arvalid  (arvalid),
    .axi_arready  (arready),
    .axi_rid      (rid),
    .axi_rdata    (rdata),
    .axi_rresp    (rresp),
    .axi_rlast    (rlast),
    .axi_rvalid   (rvalid),
    .axi_rready   (rready),
    .cfg_latency  (cfg_latency),
    .served_count (served_count),
    .dbg_state_o  (dbg_state)
  );

  // Clock and reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // R monitor: records every beat that completes at the next rising edge
  always @(negedge clock) begin
    if (!reset && rvalid && rready) begin
      rx_q.push_back({rid, rdata, rresp, rlast});
      rx_cyc.push_back(cyc);
    end
  end

  always @(posedge clock) begin
    if (rr_mode) begin
      #1;
      rready = ($urandom_range(0, 3) != 0);
    end
  end

  // Reference model: expected beats of one accepted burst
  function automatic void model_push(input logic [5:0] id, input logic [31:0] addr,
                                     input logic [3:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    logic [31:0] a;
    logic [1:0]  resp;
    resp = (burst[1] || size > 3'd3) ? 2'b10 : 2'b00;
    for (int b = 0; b <= int'(len); b++) begin
      a = addr + ((burst == 2'b00) ? 32'd0 : (32'(b) << size));
      exp_q.push_back({id, a, a, resp, (b == int'(len))});
    end
    exp_served++;
  endfunction

  // Driver: offer one AR, hold it until accepted
  task automatic send_ar(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int hs_cyc);
    bit done;
    done = 0;
    hs_cyc = -1;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clock);
      if (arready) begin
        hs_cyc = cyc;
        done = 1;
      end
      @(posedge clock); #1;
    end
    arvalid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL ar_accept: id %0d not accepted, required acceptance within 1000 cycles", id);
    end else begin
      model_push(id, addr, len, size, burst);
    end
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (rx_q.size() >= n) begin
        ok = 1;
        break;
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; arvalid = 1'b0; rready = 1'b0; cfg_latency = 16'd0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (arready !== 1'b0) begin errors++; $display("FAIL rst_arready got %b exp 0", arready); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b exp 0", rvalid); end
    checks++; if (rlast !== 1'b0) begin errors++; $display("FAIL rst_rlast got %b exp 0", rlast); end
    checks++; if (rid !== 6'd0) begin errors++; $display("FAIL rst_rid got %h exp 0", rid); end
    checks++; if (rdata !== 64'd0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rdata); end
    checks++; if (rresp !== 2'b00) begin errors++; $display("FAIL rst_rresp got %b exp 00", rresp); end
    checks++; if (served_count !== 32'd0) begin errors++; $display("FAIL rst_served got %0d exp 0", served_count); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state got %0d exp IDLE", dbg_state); end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL rel_arready got %b exp 1", arready); end
    @(posedge clock); #1;
  endtask

  task automatic test_single_incr();
    int hs, d;
    bit ok;
    logic [BW-1:0] e, r;
    rr_mode = 0; rready = 1'b1; cfg_latency = 16'd4;
    send_ar(6'd3, 32'h100, 4'd3, 3'd3, BURST_INCR, hs);
    wait_beats(4, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t1_beats got %0d exp 4", rx_q.size()); end
    if (rx_cyc.size() > 0) begin
      d = rx_cyc[0] - hs;
      checks++; if (d < 4 || d > 5) begin errors++; $display("FAIL t1_latency got %0d exp 4..5", d); end
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); void'(rx_cyc.pop_front());
      checks++; if (r !== e) begin errors++; $display("FAIL t1_beat got %h exp %h", r, e); end
    end
    checks++; if (served_count !== 32'(exp_served)) begin errors++; $display("FAIL t1_served got %0d exp %0d", served_count, exp_served); end
  endtask

  task automatic test_backpressure();
    int hs;
    bit stalled;
    logic [73:0] held;
    logic [BW-1:0] e, r;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    stalled = 0; held = '0;
    rr_mode = 0; rready = 1'b0; cfg_latency = 16'd4;
    send_ar(6'd5, 32'h2000, 4'd3, 3'd3, BURST_INCR, hs);
    for (int i = 0; i < 80 && rx_q.size() < 4; i++) begin
      rready = pat[i % 4];
      @(negedge clock);
      if (stalled) begin
        checks++;
        if ({rvalid, rid, rdata, rresp, rlast} !== held) begin
          errors++; $display("FAIL t2_hold got %h exp %h", {rvalid, rid, rdata, rresp, rlast}, held);
        end
      end
      stalled = rvalid && !rready;
      held = {rvalid, rid, rdata, rresp, rlast};
      @(posedge clock); #1;
    end
    rready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (rx_q.size() != 4) begin errors++; $display("FAIL t2_count got %0d exp 4", rx_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); void'(rx_cyc.pop_front());
      checks++; if (r !== e) begin errors++; $display("FAIL t2_beat got %h exp %h", r, e); end
    end
    checks++; if (served_count !== 32'(exp_served)) begin errors++; $display("FAIL t2_served got %0d exp %0d", served_count, exp_served); end
  endtask

  task automatic test_queue_full();
    int hs [9];
    bit ok;
    logic [BW-1:0] e, r;
    rr_mode = 0; rready = 1'b0; cfg_latency = 16'd20;
    for (int k = 0; k < 9; k++) begin
      send_ar(6'($urandom_range(0, 63)), $urandom(), 4'($urandom_range(0, 3)),
              3'($urandom_range(0, 3)), 2'($urandom_range(0, 1)), hs[k]);
    end
    for (int k = 1; k < 8; k++) begin
      checks++; if (hs[k] != hs[0] + k) begin errors++; $display("FAIL t3_accept%0d got cycle %0d exp %0d", k, hs[k], hs[0] + k); end
    end
    checks++; if (hs[8] != hs[0] + 21) begin errors++; $display("FAIL t3_ninth got cycle %0d exp %0d", hs[8], hs[0] + 21); end
    rready = 1'b1;
    wait_beats(exp_q.size(), 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t3_beats got %0d exp %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); void'(rx_cyc.pop_front());
      checks++; if (r !== e) begin errors++; $display("FAIL t3_beat got %h exp %h", r, e); end
    end
    checks++; if (served_count !== 32'(exp_served)) begin errors++; $display("FAIL t3_served got %0d exp %0d", served_count, exp_served); end
  endtask

  task automatic test_errors();
    int hs;
    bit ok;
    logic [BW-1:0] e, r;
    rr_mode = 1; cfg_latency = 16'd1;
    send_ar(6'd9, $urandom(), 4'd3, 3'd3, BURST_WRAP, hs);
    send_ar(6'd10, $urandom(), 4'd2, 3'd4, BURST_INCR, hs);
    wait_beats(7, 200, ok);
    rr_mode = 0; rready = 1'b1;
    checks++; if (!ok) begin errors++; $display("FAIL t4_beats got %0d exp 7", rx_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); void'(rx_cyc.pop_front());
      checks++; if (r !== e) begin errors++; $display("FAIL t4_beat got %h exp %h", r, e); end
    end
    checks++; if (served_count !== 32'(exp_served)) begin errors++; $display("FAIL t4_served got %0d exp %0d", served_count, exp_served); end
  endtask

  task automatic test_back_to_back();
    int hs;
    bit ok;
    logic [BW-1:0] e, r;
    rr_mode = 0; rready = 1'b1; cfg_latency = 16'd10;
    send_ar(6'd1, $urandom(), 4'd0, 3'd2, BURST_INCR, hs);
    send_ar(6'd2, 32'h40, 4'd2, 3'd3, BURST_FIXED, hs);
    wait_beats(4, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t5_beats got %0d exp 4", rx_q.size()); end
    for (int i = 1; i < rx_cyc.size(); i++) begin
      checks++; if (rx_cyc[i] != rx_cyc[0] + i) begin errors++; $display("FAIL t5_gap beat %0d got cycle %0d exp %0d", i, rx_cyc[i], rx_cyc[0] + i); end
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); void'(rx_cyc.pop_front());
      checks++; if (r !== e) begin errors++; $display("FAIL t5_beat got %h exp %h", r, e); end
    end
    checks++; if (served_count !== 32'(exp_served)) begin errors++; $display("FAIL t5_served got %0d exp %0d", served_count, exp_served); end
  endtask

  task automatic test_reset_mid_burst();
    int hs;
    bit saw;
    logic [BW-1:0] e, r;
    rr_mode = 0; rready = 1'b0; cfg_latency = 16'd2;
    for (int k = 0; k < 4; k++) begin
      send_ar(6'(k + 20), 32'h3000 + 32'(k) * 32'h100, 4'd3, 3'd3, BURST_INCR, hs);
    end
    rready = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL t6_rvalid got %b exp 0", rvalid); end
    checks++; if (served_count !== 32'd0) begin errors++; $display("FAIL t6_served got %0d exp 0", served_count); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL t6_state got %0d exp IDLE", dbg_state); end
    @(posedge clock); #1;
    reset = 1'b0;
    checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL t6_pre_beats got %0d exp 1", rx_q.size()); end
    if (rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); void'(rx_cyc.pop_front());
      checks++; if (r !== e) begin errors++; $display("FAIL t6_beat got %h exp %h", r, e); end
    end
    exp_q.delete(); rx_q.delete(); rx_cyc.delete();
    exp_served = 0;
    saw = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (rvalid) saw = 1;
    end
    @(posedge clock); #1;
    checks++; if (saw) begin errors++; $display("FAIL t6_stale got rvalid 1 exp 0"); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL t6_stale_beats got %0d exp 0", rx_q.size()); end
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL t6_arready got %b exp 1", arready); end
  endtask

  task automatic test_random();
    int hs;
    bit ok;
    logic [31:0] addr;
    logic [BW-1:0] e, r;
    rr_mode = 1; cfg_latency = 16'($urandom_range(0, 6));
    for (int k = 0; k < 24; k++) begin
      addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFC0 + 32'($urandom_range(0, 63)) : $urandom();
      send_ar(6'($urandom_range(0, 63)), addr, 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 4)), 2'($urandom_range(0, 3)), hs);
    end
    wait_beats(exp_q.size(), 3000, ok);
    rr_mode = 0; rready = 1'b1;
    checks++; if (!ok) begin errors++; $display("FAIL rnd_beats got %0d exp %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); void'(rx_cyc.pop_front());
      checks++; if (r !== e) begin errors++; $display("FAIL rnd_beat got %h exp %h", r, e); end
    end
    checks++; if (served_count !== 32'(exp_served)) begin errors++; $display("FAIL rnd_served got %0d exp %0d", served_count, exp_served); end
  endtask

  initial begin
    test_reset();
    test_single_incr();
    test_backpressure();
    test_queue_full();
    test_errors();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
